// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat card path.
// Holds the shoe FSM states, the card/rank limits and the rank wrap helper.
package baccarat_pkg;

    typedef enum logic [2:0] {
        FILL,
        PICK,
        PROBE,
        READY,
        EMPTY
    } shoe_state_t;

    localparam int RANK_MIN                = 1;
    localparam int RANK_MAX                = 13;
    localparam int CARDS_PER_RANK_PER_DECK = 4;
    localparam int CARDS_PER_DECK          = 52;

    function automatic logic [3:0] nextRank(input logic [3:0] rank);
        return (rank == 4'(RANK_MAX)) ? 4'(RANK_MIN) : rank + 4'd1;
    endfunction

endpackage

// File: rtl/rank_counter13.sv
// Free-running 1..13 wrap counter; the human timing of key presses against
// this counter is the only source of randomness in card selection.
module rank_counter13
    import baccarat_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    output logic [3:0] rank_o
);

    logic [3:0] rank_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rank_q <= 4'(RANK_MIN);
        end else begin
            rank_q <= nextRank(rank_q);
        end
    end

    assign rank_o = rank_q;

endmodule

// File: rtl/card_shoe.sv
// Finite multi-deck shoe: keeps one pre-drawn card presented on new_card and
// removes it from the per-rank counts when the sequencer consumes it.
module card_shoe
    import baccarat_pkg::*;
#(
    parameter int DECKS = 1
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       shuffle,
    input  logic       draw_req,
    output logic [3:0] new_card,
    output logic       card_valid,
    output logic       shoe_empty,
    output logic [8:0] cards_left
);

    localparam logic [5:0] FULL_RANK = 6'(CARDS_PER_RANK_PER_DECK * DECKS);
    localparam logic [8:0] FULL_SHOE = 9'(CARDS_PER_DECK * DECKS);

    shoe_state_t state_q;
    logic [5:0]  rankCount_q [RANK_MAX];
    logic [8:0]  cardsLeft_q;
    logic [3:0]  cand_q;
    logic [3:0]  newCard_q;
    logic        cardValid_q;
    logic        shoeEmpty_q;
    logic [3:0]  rc;

    rank_counter13 u_rankCounter (
        .clock  (clock),
        .resetb (resetb),
        .rank_o (rc)
    );

    // Outputs are registered alongside the state so they always match it:
    // valid only in READY, empty only in EMPTY.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= PICK;
            cardsLeft_q <= FULL_SHOE;
            cand_q      <= 4'(RANK_MIN);
            newCard_q   <= 4'd0;
            cardValid_q <= 1'b0;
            shoeEmpty_q <= 1'b0;
            for (int i = 0; i < RANK_MAX; i++) begin
                rankCount_q[i] <= FULL_RANK;
            end
        end else if (shuffle) begin
            // A draw coinciding with shuffle is dropped on purpose.
            state_q     <= FILL;
            newCard_q   <= 4'd0;
            cardValid_q <= 1'b0;
            shoeEmpty_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    cardsLeft_q <= FULL_SHOE;
                    for (int i = 0; i < RANK_MAX; i++) begin
                        rankCount_q[i] <= FULL_RANK;
                    end
                    state_q <= PICK;
                end
                PICK: begin
                    cand_q  <= rc;
                    state_q <= PROBE;
                end
                PROBE: begin
                    if (rankCount_q[cand_q - 4'd1] != 6'd0) begin
                        state_q     <= READY;
                        newCard_q   <= cand_q;
                        cardValid_q <= 1'b1;
                    end else begin
                        cand_q <= nextRank(cand_q);
                    end
                end
                READY: begin
                    if (draw_req) begin
                        rankCount_q[cand_q - 4'd1] <= rankCount_q[cand_q - 4'd1] - 6'd1;
                        cardsLeft_q <= cardsLeft_q - 9'd1;
                        newCard_q   <= 4'd0;
                        cardValid_q <= 1'b0;
                        if (cardsLeft_q == 9'd1) begin
                            state_q     <= EMPTY;
                            shoeEmpty_q <= 1'b1;
                        end else begin
                            state_q <= PICK;
                        end
                    end
                end
                EMPTY: begin
                    state_q <= EMPTY;
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign new_card   = newCard_q;
    assign card_valid = cardValid_q;
    assign shoe_empty = shoeEmpty_q;
    assign cards_left = cardsLeft_q;

endmodule

// File: tb/tb_card_shoe.sv
// Randomized bench for card_shoe: a 1-deck and an 8-deck instance are checked
// against a per-rank remaining-card model of the shoe.
module tb_card_shoe;

    logic       clock = 1'b0;
    logic [1:0] resetbV = 2'b11;
    logic [1:0] shuffleV = 2'b00;
    logic [1:0] drawV = 2'b00;
    logic [3:0] newCardV [2];
    logic [1:0] validV;
    logic [1:0] emptyV;
    logic [8:0] leftV [2];

    int compareCount = 0;
    int mismatchCount = 0;
    int modelCount [14];
    int drawnCount [14];

    always #5 clock = ~clock;

    card_shoe #(.DECKS(1)) dut1 (
        .clock      (clock),
        .resetb     (resetbV[0]),
        .shuffle    (shuffleV[0]),
        .draw_req   (drawV[0]),
        .new_card   (newCardV[0]),
        .card_valid (validV[0]),
        .shoe_empty (emptyV[0]),
        .cards_left (leftV[0])
    );

    card_shoe #(.DECKS(8)) dut8 (
        .clock      (clock),
        .resetb     (resetbV[1]),
        .shuffle    (shuffleV[1]),
        .draw_req   (drawV[1]),
        .new_card   (newCardV[1]),
        .card_valid (validV[1]),
        .shoe_empty (emptyV[1]),
        .cards_left (leftV[1])
    );

    function automatic int deckCount(input int d);
        return (d == 0) ? 1 : 8;
    endfunction

    function automatic int modelLeft();
        int s = 0;
        for (int r = 1; r <= 13; r++) s += modelCount[r];
        return s;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic refillModel(input int d);
        for (int r = 0; r < 14; r++) modelCount[r] = (r >= 1) ? 4 * deckCount(d) : 0;
    endtask

    task automatic waitValid(input int d, input int limit, output bit ok);
        int c = 0;
        while (c < limit && !validV[d]) begin
            tick();
            c++;
        end
        ok = validV[d];
        checkOutput("validWithinBound", int'(ok), 1);
    endtask

    task automatic applyStimulus(input int d, input bit doDraw, input bit doShuffle);
        drawV[d] = doDraw;
        shuffleV[d] = doShuffle;
        tick();
        drawV[d] = 1'b0;
        shuffleV[d] = 1'b0;
    endtask

    task automatic applyReset(input int d);
        resetbV[d] = 1'b0;
        #2;
        checkOutput("resetValid", int'(validV[d]), 0);
        checkOutput("resetCard", int'(newCardV[d]), 0);
        checkOutput("resetEmpty", int'(emptyV[d]), 0);
        checkOutput("resetLeft", int'(leftV[d]), 52 * deckCount(d));
        tick();
        #2;
        resetbV[d] = 1'b1;
        refillModel(d);
        tick();
    endtask

    // Draws n cards, each only once presented; optionally pokes draw_req in the
    // cycle right after an accepted draw, which the shoe must ignore.
    task automatic drawCards(input int d, input int n, input bit poke, input bit fullDrain);
        bit ok;
        int r;
        for (int r2 = 0; r2 < 14; r2++) drawnCount[r2] = 0;
        for (int i = 0; i < n; i++) begin
            waitValid(d, 15, ok);
            if (!ok) return;
            r = int'(newCardV[d]);
            checkOutput("rankInRange", int'(r >= 1 && r <= 13), 1);
            if (r >= 1 && r <= 13) begin
                checkOutput("rankAvailable", int'(modelCount[r] > 0), 1);
                if (modelCount[r] > 0) modelCount[r]--;
                drawnCount[r]++;
            end
            applyStimulus(d, 1'b1, 1'b0);
            checkOutput("validDrop", int'(validV[d]), 0);
            checkOutput("cardsLeft", int'(leftV[d]), modelLeft());
            if (poke && ($urandom_range(0, 2) == 0)) begin
                applyStimulus(d, 1'b1, 1'b0);
                checkOutput("pickDrawIgnored", int'(leftV[d]), modelLeft());
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        if (fullDrain) begin
            checkOutput("drainEmpty", int'(emptyV[d]), 1);
            checkOutput("drainLeft", int'(leftV[d]), 0);
            checkOutput("drainValid", int'(validV[d]), 0);
            checkOutput("drainCard", int'(newCardV[d]), 0);
            for (int k = 1; k <= 13; k++) begin
                checkOutput($sformatf("histogram%0d", k), drawnCount[k], 4 * deckCount(d));
            end
        end
    endtask

    initial begin : main
        bit ok;
        int held;
        #2;

        // Reset and idle stability on the 1-deck shoe.
        applyReset(0);
        waitValid(0, 14, ok);
        checkOutput("idleLeft", int'(leftV[0]), 52);
        checkOutput("idleEmpty", int'(emptyV[0]), 0);
        checkOutput("idleRank", int'(newCardV[0] >= 1 && newCardV[0] <= 13), 1);
        held = int'(newCardV[0]);
        repeat (100) begin
            tick();
            checkOutput("idleStable", int'(newCardV[0]), held);
        end

        // Full drain, then draws in EMPTY are ignored.
        drawCards(0, 52, 1'b1, 1'b1);
        repeat (5) begin
            applyStimulus(0, 1'b1, 1'b0);
            tick();
            checkOutput("emptyHold", int'(emptyV[0]), 1);
            checkOutput("emptyLeft", int'(leftV[0]), 0);
        end

        // Shuffle from EMPTY.
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("fillEmpty", int'(emptyV[0]), 0);
        checkOutput("fillValid", int'(validV[0]), 0);
        tick();
        checkOutput("fillLeft", int'(leftV[0]), 52);
        waitValid(0, 13, ok);
        refillModel(0);

        // Shuffle wins over a coincident draw.
        drawCards(0, 10, 1'b0, 1'b0);
        waitValid(0, 15, ok);
        applyStimulus(0, 1'b1, 1'b1);
        tick();
        checkOutput("collisionLeft", int'(leftV[0]), 52);
        refillModel(0);
        drawCards(0, 52, 1'b1, 1'b1);

        // Async reset while searching for the next card.
        applyStimulus(0, 1'b0, 1'b1);
        refillModel(0);
        waitValid(0, 15, ok);
        applyStimulus(0, 1'b1, 1'b0);
        tick();
        #2;
        resetbV[0] = 1'b0;
        #1;
        checkOutput("asyncValid", int'(validV[0]), 0);
        checkOutput("asyncLeft", int'(leftV[0]), 52);
        checkOutput("asyncCard", int'(newCardV[0]), 0);
        #3;
        resetbV[0] = 1'b1;
        tick();
        waitValid(0, 14, ok);

        // Eight-deck shoe: reset value and a full drain.
        applyReset(1);
        drawCards(1, 416, 1'b1, 1'b1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
